rsp_s1_prep_ahbic_cmd_master: RTL



---
 rtl/rsp_s1_prep_ahbic_cmd_master.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/rsp_s1_prep_ahbic_cmd_master.sv
// AHB-Lite initiator: turns a valid/ready command stream into pipelined SINGLE transfers.
// NONSEQ one cycle after accept, response pulse two cycles later; HREADY low or a pending replay stalls cmd_ready.
module rsp_s1_prep_ahbic_cmd_master #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int ECW = 8
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [1:0]    cmd_size,
    input  logic [DW-1:0] cmd_wdata,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [2:0]    HBURST,
    output logic [DW-1:0] HWDATA,
    input  logic [DW-1:0] HRDATA,
    input  logic          HREADY,
    input  logic [1:0]    HRESP,
    output logic          rsp_valid,
    output logic          rsp_write,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [ECW-1:0] err_cnt
);

    // Address slot: what is currently driven on the bus address phase.
    logic          ap_vld_q,   ap_vld_d;
    logic [AW-1:0] ap_addr_q,  ap_addr_d;
    logic          ap_write_q, ap_write_d;
    logic [1:0]    ap_size_q,  ap_size_d;
    logic [DW-1:0] ap_wdata_q, ap_wdata_d;

    // Data slot: the transfer whose data phase is in progress.
    logic          dp_vld_q,   dp_vld_d;
    logic          dp_write_q, dp_write_d;
    logic [DW-1:0] hwdata_q,   hwdata_d;

    // Replay slot: an address phase cancelled by the first ERROR cycle.
    logic          rp_vld_q,   rp_vld_d;
    logic [AW-1:0] rp_addr_q,  rp_addr_d;
    logic          rp_write_q, rp_write_d;
    logic [1:0]    rp_size_q,  rp_size_d;
    logic [DW-1:0] rp_wdata_q, rp_wdata_d;

    logic          rsp_vld_q,   rsp_vld_d;
    logic          rsp_err_q,   rsp_err_d;
    logic          rsp_write_q, rsp_write_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ECW-1:0] err_cnt_q,  err_cnt_d;

    logic hresp_err;
    logic err_first;

    assign hresp_err = |HRESP;
    assign err_first = dp_vld_q & ~HREADY & hresp_err;
    assign cmd_ready = HREADY & ~rp_vld_q & ~err_first;

    always_comb begin
        ap_vld_d    = ap_vld_q;
        ap_addr_d   = ap_addr_q;
        ap_write_d  = ap_write_q;
        ap_size_d   = ap_size_q;
        ap_wdata_d  = ap_wdata_q;
        dp_vld_d    = dp_vld_q;
        dp_write_d  = dp_write_q;
        hwdata_d    = hwdata_q;
        rp_vld_d    = rp_vld_q;
        rp_addr_d   = rp_addr_q;
        rp_write_d  = rp_write_q;
        rp_size_d   = rp_size_q;
        rp_wdata_d  = rp_wdata_q;
        rsp_vld_d   = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        err_cnt_d   = err_cnt_q;

        if (HREADY) begin
            dp_vld_d   = ap_vld_q;
            dp_write_d = ap_write_q;
            hwdata_d   = ap_wdata_q;

            if (rp_vld_q) begin
                ap_vld_d   = 1'b1;
                ap_addr_d  = rp_addr_q;
                ap_write_d = rp_write_q;
                ap_size_d  = rp_size_q;
                ap_wdata_d = rp_wdata_q;
                rp_vld_d   = 1'b0;
            end else if (cmd_valid && cmd_ready) begin
                ap_vld_d   = 1'b1;
                ap_addr_d  = cmd_addr;
                ap_write_d = cmd_write;
                ap_size_d  = cmd_size;
                ap_wdata_d = cmd_wdata;
            end else begin
                ap_vld_d   = 1'b0;
            end

            if (dp_vld_q) begin
                rsp_vld_d   = 1'b1;
                rsp_err_d   = hresp_err;
                rsp_write_d = dp_write_q;
                rsp_rdata_d = dp_write_q ? '0 : HRDATA;
                if (hresp_err && (err_cnt_q != '1)) begin
                    err_cnt_d = err_cnt_q + ECW'(1);
                end
            end
        end else if (err_first && ap_vld_q) begin
            // Park the pending address phase and drop to IDLE for the second ERROR cycle.
            rp_vld_d   = 1'b1;
            rp_addr_d  = ap_addr_q;
            rp_write_d = ap_write_q;
            rp_size_d  = ap_size_q;
            rp_wdata_d = ap_wdata_q;
            ap_vld_d   = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ap_vld_q    <= 1'b0;
            ap_addr_q   <= '0;
            ap_write_q  <= 1'b0;
            ap_size_q   <= 2'b10;
            ap_wdata_q  <= '0;
            dp_vld_q    <= 1'b0;
            dp_write_q  <= 1'b0;
            hwdata_q    <= '0;
            rp_vld_q    <= 1'b0;
            rp_addr_q   <= '0;
            rp_write_q  <= 1'b0;
            rp_size_q   <= 2'b10;
            rp_wdata_q  <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            ap_vld_q    <= ap_vld_d;
            ap_addr_q   <= ap_addr_d;
            ap_write_q  <= ap_write_d;
            ap_size_q   <= ap_size_d;
            ap_wdata_q  <= ap_wdata_d;
            dp_vld_q    <= dp_vld_d;
            dp_write_q  <= dp_write_d;
            hwdata_q    <= hwdata_d;
            rp_vld_q    <= rp_vld_d;
            rp_addr_q   <= rp_addr_d;
            rp_write_q  <= rp_write_d;
            rp_size_q   <= rp_size_d;
            rp_wdata_q  <= rp_wdata_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_err_q   <= rsp_err_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign HADDR     = ap_addr_q;
    assign HTRANS    = ap_vld_q ? 2'b10 : 2'b00;
    assign HWRITE    = ap_write_q;
    assign HSIZE     = {1'b0, ap_size_q};
    assign HBURST    = 3'b000;
    assign HWDATA    = hwdata_q;
    assign rsp_valid = rsp_vld_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign err_cnt   = err_cnt_q;

endmodule
